// File: rtl/fir_sched_pkg.sv
// Shared definitions for the time-shared FIR scheduler: width defaults,
// controller state encoding, channel-index width and the tag record that
// travels alongside each sample through the FIR latency.
package fir_sched_pkg;

    localparam int DW_DEF   = 8;
    localparam int OW_DEF   = 15;
    // Widest channel index ever needed (N_CH is at most 8).
    localparam int CH_W_MAX = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    // Channel index width; never below one bit.
    function automatic int calc_cw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Tag pushed for every cycle the FIR is fed: flush samples are discards.
    typedef struct packed {
        logic                valid;
        logic                discard;
        logic [CH_W_MAX-1:0] ch;
    } tag_t;

endpackage

// File: rtl/fir_share_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after the pointer,
// wrapping around. Purely combinational; the caller owns the pointer.
module rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CW   = calc_cw(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   ptr,
    output logic [N_CH-1:0] grant,
    output logic [CW-1:0]   idx
);

    // Scan from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_CH]) begin
                idx = CW'((int'(ptr) + k) % N_CH);
            end
        end
        if (|req) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fir_share_sched.sv
// Time-shares one FIR between N_CH sources. A round-robin grant serves up
// to BURST samples; whenever the granted channel differs from the one whose
// samples fill the FIR delay line, TAPS zero samples are pushed first.
// A tag pipe matched to the FIR latency routes results back to channels.
module fir_share_sched
    import fir_sched_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int DW    = DW_DEF,
    parameter  int OW    = OW_DEF,
    parameter  int BURST = 4,
    parameter  int TAPS  = 4,
    parameter  int LAT   = 1,
    localparam int CW    = calc_cw(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    req_valid,
    input  logic [N_CH*DW-1:0] req_data,
    output logic [N_CH-1:0]    req_ready,
    output logic [DW-1:0]      fir_data_in,
    output logic               fir_valid_in,
    input  logic [OW-1:0]      fir_data_out,
    output logic               out_valid,
    output logic [OW-1:0]      out_data,
    output logic [CW-1:0]      out_ch,
    output logic               busy
);

    localparam int FCW = $clog2(TAPS + 1);
    localparam int BCW = $clog2(BURST + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cur_q, cur_d;
    logic [CW-1:0]    last_q, last_d;
    logic             hist_q, hist_d;
    logic [CW-1:0]    rr_q, rr_d;
    logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [BCW-1:0]   burst_cnt_q, burst_cnt_d;
    logic             fir_valid_q, fir_valid_d;
    logic [DW-1:0]    fir_data_q, fir_data_d;
    tag_t             fir_tag_q, fir_tag_d;
    logic             out_valid_q;
    logic [OW-1:0]    out_data_q;
    logic [CW-1:0]    out_ch_q;

    logic [N_CH-1:0]  arb_grant;
    logic [CW-1:0]    arb_idx;
    logic             arb_any;
    logic [CW-1:0]    cur_next;
    logic [LAT-1:0]   tag_vld;
    tag_t             tag_exit;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req   (req_valid),
        .ptr   (rr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign arb_any  = |arb_grant;
    assign cur_next = (int'(cur_q) == N_CH - 1) ? '0 : cur_q + 1'b1;

    // Controller next state, FIR feed and per-channel ready.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        hist_d      = hist_q;
        rr_d        = rr_q;
        flush_cnt_d = flush_cnt_q;
        burst_cnt_d = burst_cnt_q;
        fir_valid_d = 1'b0;
        fir_data_d  = '0;
        fir_tag_d   = '0;
        req_ready   = '0;
        case (state_q)
            ST_IDLE: begin
                burst_cnt_d = '0;
                if (arb_any) begin
                    cur_d = arb_idx;
                    if (!hist_q || arb_idx != last_q) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = '0;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_FLUSH: begin
                fir_valid_d       = 1'b1;
                fir_tag_d.valid   = 1'b1;
                fir_tag_d.discard = 1'b1;
                fir_tag_d.ch      = CH_W_MAX'(cur_q);
                flush_cnt_d       = flush_cnt_q + 1'b1;
                if (flush_cnt_q == FCW'(TAPS - 1)) begin
                    state_d = ST_SERVE;
                    last_d  = cur_q;
                    hist_d  = 1'b1;
                end
            end
            ST_SERVE: begin
                req_ready[cur_q] = req_valid[cur_q];
                if (req_valid[cur_q]) begin
                    fir_valid_d     = 1'b1;
                    fir_data_d      = req_data[int'(cur_q) * DW +: DW];
                    fir_tag_d.valid = 1'b1;
                    fir_tag_d.ch    = CH_W_MAX'(cur_q);
                    burst_cnt_d     = burst_cnt_q + 1'b1;
                    if (burst_cnt_q == BCW'(BURST - 1)) begin
                        state_d = ST_IDLE;
                        rr_d    = cur_next;
                    end
                end else begin
                    state_d = ST_IDLE;
                    rr_d    = cur_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state and registered FIR feed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            hist_q      <= 1'b0;
            rr_q        <= '0;
            flush_cnt_q <= '0;
            burst_cnt_q <= '0;
            fir_valid_q <= 1'b0;
            fir_data_q  <= '0;
            fir_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            hist_q      <= hist_d;
            rr_q        <= rr_d;
            flush_cnt_q <= flush_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            fir_valid_q <= fir_valid_d;
            fir_data_q  <= fir_data_d;
            fir_tag_q   <= fir_tag_d;
        end
    end

    // Tag delay line: stage LAT-1 lines up with the matching fir_data_out.
    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_pipe
            tag_t stage_q;
            if (gi == 0) begin : g_first
                // First stage takes the tag issued with fir_valid_in.
                always_ff @(posedge clk) begin
                    if (rst) stage_q <= '0;
                    else     stage_q <= fir_tag_q;
                end
            end else begin : g_next
                // Later stages just shift.
                always_ff @(posedge clk) begin
                    if (rst) stage_q <= '0;
                    else     stage_q <= g_pipe[gi-1].stage_q;
                end
            end
            assign tag_vld[gi] = stage_q.valid;
        end
    endgenerate

    assign tag_exit = g_pipe[LAT-1].stage_q;

    // Capture non-discard results with their channel tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= tag_exit.valid && !tag_exit.discard;
            if (tag_exit.valid && !tag_exit.discard) begin
                out_data_q <= fir_data_out;
                out_ch_q   <= CW'(tag_exit.ch);
            end
        end
    end

    assign fir_valid_in = fir_valid_q;
    assign fir_data_in  = fir_data_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_ch       = out_ch_q;
    assign busy         = (state_q != ST_IDLE) || fir_tag_q.valid || (|tag_vld);

endmodule

// File: tb/tb_fir_share_sched.sv
// Bench for fir_share_sched: queue-driven sources, a 4-tap FIR model with
// unknown start-up contents, and a scoreboard of expected FIR inputs and
// tagged results filled when samples are accepted.
module tb_fir_share_sched;

    localparam int N_CH  = 4;
    localparam int DW    = 8;
    localparam int OW    = 15;
    localparam int BURST = 4;
    localparam int TAPS  = 4;
    localparam int LAT   = 3;
    localparam int CW    = 2;

    typedef struct { int d; bit smp; } exp_fir_t;
    typedef struct { int d; int cyc; } obs_fir_t;
    typedef struct { int ch; int y; }  exp_out_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N_CH-1:0]    req_valid = '0;
    logic [N_CH*DW-1:0] req_data = '0;
    logic [N_CH-1:0]    req_ready;
    logic [DW-1:0]      fir_data_in;
    logic               fir_valid_in;
    logic [OW-1:0]      fir_data_out;
    logic               out_valid;
    logic [OW-1:0]      out_data;
    logic [CW-1:0]      out_ch;
    logic               busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int       src_q [N_CH][$];
    exp_fir_t exp_fir[$];
    obs_fir_t obs_fir[$];
    exp_out_t exp_out[$];
    int       lat_q[$];
    int       grant_q[$];
    int       len_q[$];
    int       n_fir = 0;
    int       n_out = 0;
    logic [N_CH-1:0] acc_vec = '0;
    bit       in_burst = 0;
    bit       tb_hist = 0;
    int       tb_last = 0;
    int       hist [TAPS-1];

    // FIR model: unknown start-up contents, no reset, LAT-cycle output delay.
    logic [DW-1:0] fir_dl [TAPS-1] = '{8'hA5, 8'h3C, 8'hF0};
    logic [OW-1:0] fir_pipe [LAT];
    logic [OW-1:0] fir_y;

    always #5 clk = ~clk;

    fir_share_sched #(
        .N_CH(N_CH), .DW(DW), .OW(OW), .BURST(BURST), .TAPS(TAPS), .LAT(LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fir_data_in  (fir_data_in),
        .fir_valid_in (fir_valid_in),
        .fir_data_out (fir_data_out),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .busy         (busy)
    );

    assign fir_y = OW'(fir_data_in) + OW'(2) * OW'(fir_dl[0])
                 + OW'(3) * OW'(fir_dl[1]) + OW'(4) * OW'(fir_dl[2]);
    assign fir_data_out = fir_pipe[LAT-1];

    always @(posedge clk) begin
        if (fir_valid_in) begin
            fir_dl[0] <= fir_data_in;
            fir_dl[1] <= fir_dl[0];
            fir_dl[2] <= fir_dl[1];
        end
        fir_pipe[0] <= fir_valid_in ? fir_y : '0;
        for (int i = 1; i < LAT; i++) fir_pipe[i] <= fir_pipe[i-1];
    end

    // Sources: pop what was accepted at this edge, present the next sample.
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < N_CH; c++) begin
            if (acc_vec[c]) void'(src_q[c].pop_front());
            req_valid[c] = (src_q[c].size() > 0);
            req_data[c*DW +: DW] = (src_q[c].size() > 0) ? DW'(src_q[c][0]) : '0;
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            acc_vec = '0;
            in_burst = 0;
            tb_hist = 0;
            exp_fir.delete();
            obs_fir.delete();
            exp_out.delete();
            lat_q.delete();
        end else begin
            acc_vec = req_valid & req_ready;
            checks++;
            if (!$onehot0(req_ready)) begin
                errors++;
                $display("FAIL ready_onehot cyc=%0d got=%b want one-hot or zero", cyc, req_ready);
            end
            if (req_ready != 0) begin
                if (!in_burst) begin
                    for (int c = 0; c < N_CH; c++)
                        if (req_ready[c]) grant_q.push_back(c);
                    len_q.push_back(0);
                    in_burst = 1;
                end
            end else begin
                in_burst = 0;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (acc_vec[c]) begin
                    int x, y;
                    x = src_q[c][0];
                    if (!tb_hist || c != tb_last) begin
                        for (int k = 0; k < TAPS-1; k++) hist[k] = 0;
                        for (int k = 0; k < TAPS; k++) exp_fir.push_back('{0, 1'b0});
                    end
                    tb_hist = 1;
                    tb_last = c;
                    y = x + 2 * hist[0] + 3 * hist[1] + 4 * hist[2];
                    hist[2] = hist[1];
                    hist[1] = hist[0];
                    hist[0] = x;
                    exp_fir.push_back('{x, 1'b1});
                    exp_out.push_back('{c, y});
                    if (len_q.size() > 0) len_q[len_q.size()-1] += 1;
                    $display("accept ch=%0d data=%0d expect y=%0d cyc=%0d", c, x, y, cyc);
                end
            end
            if (fir_valid_in) begin
                obs_fir.push_back('{int'(fir_data_in), cyc});
                n_fir++;
            end
            while (exp_fir.size() > 0 && obs_fir.size() > 0) begin
                exp_fir_t e;
                obs_fir_t o;
                e = exp_fir.pop_front();
                o = obs_fir.pop_front();
                checks++;
                if (o.d !== e.d) begin
                    errors++;
                    $display("FAIL fir_data_in cyc=%0d got=%0d want=%0d", o.cyc, o.d, e.d);
                end
                if (e.smp) lat_q.push_back(o.cyc);
            end
            if (out_valid) begin
                n_out++;
                checks++;
                if (exp_out.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected cyc=%0d got ch=%0d data=%0d want no result", cyc, out_ch, out_data);
                end else begin
                    exp_out_t e;
                    e = exp_out.pop_front();
                    $display("result ch=%0d data=%0d cyc=%0d", out_ch, out_data, cyc);
                    if (int'(out_ch) !== e.ch || int'(out_data) !== e.y) begin
                        errors++;
                        $display("FAIL out_result cyc=%0d got ch=%0d data=%0d want ch=%0d data=%0d",
                                 cyc, out_ch, out_data, e.ch, e.y);
                    end
                    if (lat_q.size() > 0) begin
                        int t0;
                        t0 = lat_q.pop_front();
                        checks++;
                        if (cyc - t0 != LAT + 1) begin
                            errors++;
                            $display("FAIL out_latency cyc=%0d got=%0d want=%0d", cyc, cyc - t0, LAT + 1);
                        end
                    end
                end
            end
        end
    end

    // Wait until every source is empty and every expected result has appeared.
    task automatic wait_drain(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            bit empty;
            @(negedge clk);
            #1;
            empty = (exp_out.size() == 0) && (lat_q.size() == 0) && !busy;
            for (int c = 0; c < N_CH; c++) if (src_q[c].size() > 0) empty = 0;
            if (empty) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || fir_valid_in !== 1'b0 || fir_data_in !== '0) begin
            errors++;
            $display("FAIL reset_feed got ready=%b fv=%b fd=%0d want 0/0/0", req_ready, fir_valid_in, fir_data_in);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got ov=%b od=%0d oc=%0d busy=%b want 0/0/0/0", out_valid, out_data, out_ch, busy);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single_flush();
        int f0, o0;
        bit ok;
        grant_q.delete(); len_q.delete();
        f0 = n_fir; o0 = n_out;
        src_q[0].push_back(1); src_q[0].push_back(7); src_q[0].push_back(12);
        wait_drain(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_drain got timeout want drained"); end
        checks++;
        if (grant_q.size() != 1 || grant_q[0] != 0 || len_q[0] != 3) begin
            errors++;
            $display("FAIL single_grant got bursts=%0d want one burst ch0 len3", grant_q.size());
        end
        checks++;
        if (n_fir - f0 != TAPS + 3 || n_out - o0 != 3) begin
            errors++;
            $display("FAIL single_counts got fir=%0d out=%0d want fir=%0d out=3", n_fir - f0, n_out - o0, TAPS + 3);
        end
    endtask

    task automatic test_round_robin();
        int f0, o0;
        bit ok;
        int want[4] = '{1, 2, 1, 2};
        grant_q.delete(); len_q.delete();
        f0 = n_fir; o0 = n_out;
        for (int i = 0; i < 8; i++) begin
            src_q[1].push_back($urandom_range(1, 255));
            src_q[2].push_back($urandom_range(1, 255));
        end
        wait_drain(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_drain got timeout want drained"); end
        checks++;
        if (grant_q.size() != 4) begin
            errors++;
            $display("FAIL rr_bursts got=%0d want=4", grant_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grant_q[i] != want[i] || len_q[i] != BURST) begin
                    errors++;
                    $display("FAIL rr_grant idx=%0d got ch=%0d len=%0d want ch=%0d len=%0d",
                             i, grant_q[i], len_q[i], want[i], BURST);
                end
            end
        end
        checks++;
        if (n_fir - f0 != 4 * (TAPS + BURST) || n_out - o0 != 16) begin
            errors++;
            $display("FAIL rr_counts got fir=%0d out=%0d want fir=%0d out=16", n_fir - f0, n_out - o0, 4 * (TAPS + BURST));
        end
    endtask

    task automatic test_back_to_back();
        int f0, o0;
        bit ok;
        int want_len[3] = '{4, 4, 2};
        grant_q.delete(); len_q.delete();
        f0 = n_fir; o0 = n_out;
        for (int i = 0; i < 10; i++) src_q[3].push_back(20 + 17 * i);
        wait_drain(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_drain got timeout want drained"); end
        checks++;
        if (grant_q.size() != 3) begin
            errors++;
            $display("FAIL b2b_bursts got=%0d want=3", grant_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (grant_q[i] != 3 || len_q[i] != want_len[i]) begin
                    errors++;
                    $display("FAIL b2b_grant idx=%0d got ch=%0d len=%0d want ch=3 len=%0d",
                             i, grant_q[i], len_q[i], want_len[i]);
                end
            end
        end
        checks++;
        if (n_fir - f0 != TAPS + 10 || n_out - o0 != 10) begin
            errors++;
            $display("FAIL b2b_counts got fir=%0d out=%0d want fir=%0d out=10", n_fir - f0, n_out - o0, TAPS + 10);
        end
    endtask

    task automatic test_valid_drop();
        int f0;
        bit ok;
        grant_q.delete(); len_q.delete();
        f0 = n_fir;
        src_q[0].push_back(90); src_q[0].push_back(91);
        src_q[1].push_back(5); src_q[1].push_back(6); src_q[1].push_back(200);
        wait_drain(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL drop_drain got timeout want drained"); end
        checks++;
        if (grant_q.size() != 2 || grant_q[0] != 0 || grant_q[1] != 1 || len_q[0] != 2 || len_q[1] != 3) begin
            errors++;
            $display("FAIL drop_grant got bursts=%0d want ch0 len2 then ch1 len3", grant_q.size());
        end
        checks++;
        if (n_fir - f0 != 2 * TAPS + 5) begin
            errors++;
            $display("FAIL drop_fir_count got=%0d want=%0d", n_fir - f0, 2 * TAPS + 5);
        end
    endtask

    task automatic test_reset_midburst();
        int o0;
        bit ok, seen;
        for (int i = 0; i < 4; i++) src_q[2].push_back(60 + i);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (req_ready[2]) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_grant got timeout want ch2 ready"); end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (req_ready !== '0 || fir_valid_in !== 1'b0 || fir_data_in !== '0 ||
            out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs got ready=%b fv=%b fd=%0d ov=%b od=%0d oc=%0d busy=%b want all 0",
                     req_ready, fir_valid_in, fir_data_in, out_valid, out_data, out_ch, busy);
        end
        grant_q.delete(); len_q.delete();
        o0 = n_out;
        wait_drain(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_drain got timeout want drained"); end
        checks++;
        if (grant_q.size() != 1 || grant_q[0] != 2 || len_q[0] != 2 || n_out - o0 != 2) begin
            errors++;
            $display("FAIL rstmid_after got bursts=%0d out=%0d want one ch2 burst len2, 2 results",
                     grant_q.size(), n_out - o0);
        end
    endtask

    initial begin
        test_reset();
        test_single_flush();
        test_round_robin();
        test_back_to_back();
        test_valid_drop();
        test_reset_midburst();
        repeat (LAT + 4) @(posedge clk);
        checks++;
        if (exp_fir.size() != 0 || obs_fir.size() != 0) begin
            errors++;
            $display("FAIL fir_stream_left got exp=%0d obs=%0d want 0/0", exp_fir.size(), obs_fir.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
